// File: rtl/mmio_uart_hub_pkg.sv
// Shared constants for mmio_uart_hub: register map, STATUS bit
// positions and serialiser state encoding.
package mmio_uart_hub_pkg;

   localparam logic [31:0] UART_ADDR_DEF    = 32'hF6FF_F000;
   localparam logic [31:0] STATUS_ADDR_DEF  = 32'hF6FF_F004;
   localparam logic [31:0] COUNTER_ADDR_DEF = 32'hF6FF_F008;

   localparam int unsigned STAT_EMPTY = 0;
   localparam int unsigned STAT_FULL  = 1;
   localparam int unsigned STAT_BUSY  = 2;
   localparam int unsigned STAT_OVF   = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_e;

endpackage

// File: rtl/mmio_uart_hub_if.sv
// Memory-access bus seen by the hub: one-cycle load/store strobes,
// combinational claim (hit) and registered load data.
interface mmio_uart_hub_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic        re;
   logic        hit;
   logic [31:0] rdata;

   modport master (
      output addr, wdata, we, re,
      input  hit, rdata
   );

   modport slave (
      input  addr, wdata, we, re,
      output hit, rdata
   );
endinterface

// File: rtl/mmio_uart_hub_sync_fifo.sv
// Synchronous FIFO with naturally wrapping pointers and a separate
// occupancy count; head entry is visible combinationally on rdata.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full    = cnt_q == CW'(DEPTH);
   assign empty   = cnt_q == '0;
   assign count   = cnt_q;
   assign rdata   = mem_q[rptr_q];
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves this cycle
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end
endmodule

// File: rtl/mmio_uart_hub.sv
// MMIO hub: TX FIFO + 8N1 serialiser, STATUS with sticky overflow,
// and a loadable cycle counter built only with MMIO_HUB_COUNTER_EN.
module mmio_uart_hub
   import mmio_uart_hub_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [31:0] UART_ADDR    = UART_ADDR_DEF,
   parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF,
   parameter logic [31:0] COUNTER_ADDR = COUNTER_ADDR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   mmio_uart_hub_if.slave  bus,
   output logic            uart_tx
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH+1);
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);

   logic          sel_uart, sel_stat, sel_cnt;
   logic          wr_uart, pop, full, empty, busy;
   logic [7:0]    head;
   logic [CW-1:0] fifo_cnt;
   logic [31:0]   status, cnt_val;

   tx_state_e     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          baud_end;

   assign sel_uart = bus.addr == UART_ADDR;
   assign sel_stat = bus.addr == STATUS_ADDR;

`ifdef MMIO_HUB_COUNTER_EN
   logic [31:0] cnt_q, cnt_d;

   assign sel_cnt = bus.addr == COUNTER_ADDR;
   assign cnt_val = cnt_q;

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (bus.we && sel_cnt) cnt_d = bus.wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   logic cnt_unused;

   assign sel_cnt    = 1'b0;
   assign cnt_val    = '0;
   assign cnt_unused = ^{bus.wdata[31:8], COUNTER_ADDR};
`endif

   assign bus.hit = sel_uart | sel_stat | sel_cnt;
   assign bus.rdata = rdata_q;
   assign uart_tx = tx_q;
   assign wr_uart = bus.we & sel_uart;
   assign busy = state_q != S_IDLE;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_uart),
      .pop   (pop),
      .wdata (bus.wdata[7:0]),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_cnt)
   );

   always_comb begin
      status             = '0;
      status[15:8]       = 8'(fifo_cnt);
      status[STAT_OVF]   = ovf_q;
      status[STAT_BUSY]  = busy;
      status[STAT_FULL]  = full;
      status[STAT_EMPTY] = empty;
   end

   always_comb begin
      ovf_d = ovf_q;
      if (bus.we && sel_stat && bus.wdata[STAT_OVF]) ovf_d = 1'b0;
      if (wr_uart && full && !pop) ovf_d = 1'b1;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (bus.re && bus.hit) begin
         unique case (1'b1)
            sel_stat: rdata_d = status;
            sel_cnt:  rdata_d = cnt_val;
            default:  rdata_d = '0;
         endcase
      end
   end

   assign baud_end = baud_q == BW'(CLKS_PER_BIT-1);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               bit_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Line level follows the next state so it is registered alongside it
      unique case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         ovf_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
         rdata_q <= rdata_d;
      end
   end
endmodule

// File: tb/tb_mmio_uart_hub.sv
// Directed self-checking bench for mmio_uart_hub (CLKS_PER_BIT=4,
// FIFO_DEPTH=4); counter scenario follows MMIO_HUB_COUNTER_EN.
module tb_mmio_uart_hub;
   localparam logic [31:0] A_UART = 32'hF6FF_F000;
   localparam logic [31:0] A_STAT = 32'hF6FF_F004;
   localparam logic [31:0] A_CNT  = 32'hF6FF_F008;
   localparam logic [31:0] A_NONE = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic uart_tx;

   int n_pass = 0;
   int n_total = 0;

   mmio_uart_hub_if bus ();

   mmio_uart_hub #(
      .FIFO_DEPTH   (4),
      .CLKS_PER_BIT (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .uart_tx (uart_tx)
   );

   always #5 clk = ~clk;

   // Line receiver: samples each bit mid-way, pushes decoded bytes
   logic [7:0] rx_q [$];
   int         rx_err = 0;
   bit         mon_act = 0;
   int         mon_cyc = 0;
   logic [7:0] mon_byte;

   always @(negedge clk) begin
      if (rst) begin
         mon_act = 0;
      end else if (!mon_act) begin
         if (uart_tx == 1'b0) begin
            mon_act = 1;
            mon_cyc = 0;
         end
      end else begin
         mon_cyc++;
         if (mon_cyc % 4 == 2) begin
            if (mon_cyc / 4 == 0) begin
               if (uart_tx !== 1'b0) rx_err++;
            end else if (mon_cyc / 4 <= 8) begin
               mon_byte[mon_cyc/4-1] = uart_tx;
            end else begin
               if (uart_tx !== 1'b1) rx_err++;
               rx_q.push_back(mon_byte);
               mon_act = 0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      rx_q.delete();
      rx_err = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr = a;
      bus.wdata = d;
      bus.we = 1'b1;
      tick();
      bus.we = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
   endtask

   task automatic rd(input logic [31:0] a);
      bus.addr = a;
      bus.re = 1'b1;
      tick();
      bus.re = 1'b0;
      bus.addr = '0;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      else
         n_pass++;
   endtask

   task automatic test_reset();
      bus.addr = '0;
      bus.wdata = '0;
      bus.we = 1'b0;
      bus.re = 1'b0;
      do_reset();
      n_total++;
      if (uart_tx !== 1'b1)
         $display("FAIL reset_tx: got %b expected 1", uart_tx);
      else n_pass++;
      n_total++;
      if (bus.rdata !== 32'h0)
         $display("FAIL reset_rdata: got %h expected 0", bus.rdata);
      else n_pass++;
      n_total++;
      if (bus.hit !== 1'b0)
         $display("FAIL reset_hit: got %b expected 0", bus.hit);
      else n_pass++;
      rd(A_STAT);
      n_total++;
      if (bus.rdata !== 32'h0000_0001)
         $display("FAIL reset_status: got %h expected 1", bus.rdata);
      else n_pass++;
   endtask

   task automatic test_single_frame();
      logic [9:0] bits;
      int bad;
      bits = 10'b1_0101_0101_0;
      bad = 0;
      do_reset();
      wr(A_UART, 32'h55);
      n_total++;
      if (uart_tx !== 1'b1)
         $display("FAIL t1_after_push: got %b expected 1", uart_tx);
      else n_pass++;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (uart_tx !== bits[k/4]) bad++;
         if (k == 10) begin
            bus.addr = A_STAT;
            bus.re = 1'b1;
         end
         if (k == 11) begin
            bus.re = 1'b0;
            bus.addr = '0;
            n_total++;
            if (bus.rdata !== 32'h0000_0005)
               $display("FAIL t1_busy: got %h expected 00000005",
                        bus.rdata);
            else n_pass++;
         end
      end
      n_total++;
      if (bad != 0)
         $display("FAIL t1_waveform: got %0d bad cycles expected 0", bad);
      else n_pass++;
      tick();
      rd(A_STAT);
      n_total++;
      if (bus.rdata !== 32'h0000_0001)
         $display("FAIL t1_idle: got %h expected 00000001", bus.rdata);
      else n_pass++;
      n_total++;
      if (rx_q.size() != 1 || rx_q[0] !== 8'h55)
         $display("FAIL t1_rx: got %0d bytes expected 1 byte 55",
                  rx_q.size());
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [7:0] exp [5];
      int to;
      bit ok;
      exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         bus.addr = A_UART;
         bus.wdata = 32'(8'h11 * (i + 1));
         bus.we = 1'b1;
         tick();
      end
      bus.we = 1'b0;
      bus.addr = '0;
      rd(A_STAT);
      chk("t2_ovf_set", bus.rdata, 32'h0000_040E);
      wr(A_STAT, 32'h8);
      rd(A_STAT);
      chk("t2_ovf_clr", bus.rdata, 32'h0000_0406);
      to = 0;
      while (rx_q.size() < 5 && to < 400) begin
         tick();
         to++;
      end
      n_total++;
      if (to >= 400)
         $display("FAIL t2_timeout: got %0d frames expected 5",
                  rx_q.size());
      else n_pass++;
      repeat (60) tick();
      ok = rx_q.size() == 5;
      for (int i = 0; i < 5 && ok; i++)
         if (rx_q[i] !== exp[i]) ok = 0;
      n_total++;
      if (!ok || rx_err != 0)
         $display("FAIL t2_frames: got %0d frames err %0d expected 5 ok",
                  rx_q.size(), rx_err);
      else n_pass++;
   endtask

   task automatic test_full_pop_push();
      int to;
      bit ok;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.addr = A_UART;
         bus.wdata = 32'(8'hA0 + i);
         bus.we = 1'b1;
         tick();
      end
      bus.we = 1'b0;
      bus.addr = '0;
      repeat (37) tick();
      wr(A_UART, 32'hA5);
      rd(A_STAT);
      chk("t3_pop_push", bus.rdata, 32'h0000_0406);
      to = 0;
      while (rx_q.size() < 6 && to < 400) begin
         tick();
         to++;
      end
      ok = rx_q.size() == 6 && rx_err == 0;
      for (int i = 0; i < 6 && ok; i++)
         if (rx_q[i] !== 8'(8'hA0 + i)) ok = 0;
      n_total++;
      if (!ok)
         $display("FAIL t3_frames: got %0d frames err %0d expected 6",
                  rx_q.size(), rx_err);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      int bad;
      do_reset();
      wr(A_UART, 32'h00);
      wr(A_UART, 32'h0F);
      repeat (12) tick();
      n_total++;
      if (uart_tx !== 1'b0)
         $display("FAIL t4_mid_data: got %b expected 0", uart_tx);
      else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_total++;
      if (uart_tx !== 1'b1)
         $display("FAIL t4_tx_after_rst: got %b expected 1", uart_tx);
      else n_pass++;
      rd(A_STAT);
      chk("t4_status", bus.rdata, 32'h0000_0001);
      bad = 0;
      for (int k = 0; k < 120; k++) begin
         tick();
         if (uart_tx !== 1'b1) bad++;
      end
      n_total++;
      if (bad != 0 || rx_q.size() != 0)
         $display("FAIL t4_quiet: got %0d low cycles %0d frames expected 0",
                  bad, rx_q.size());
      else n_pass++;
   endtask

   task automatic test_counter();
      do_reset();
`ifdef MMIO_HUB_COUNTER_EN
      bus.addr = A_CNT;
      #1;
      n_total++;
      if (bus.hit !== 1'b1)
         $display("FAIL t5_hit: got %b expected 1", bus.hit);
      else n_pass++;
      rd(A_CNT);
      chk("t5_after_rst", bus.rdata, 32'h0);
      tick();
      rd(A_CNT);
      chk("t5_running", bus.rdata, 32'h2);
      wr(A_CNT, 32'hFFFF_FFFE);
      tick();
      rd(A_CNT);
      chk("t5_load", bus.rdata, 32'hFFFF_FFFF);
      tick();
      rd(A_CNT);
      chk("t5_wrap", bus.rdata, 32'h0000_0001);
`else
      rd(A_STAT);
      chk("t5_pre", bus.rdata, 32'h0000_0001);
      bus.addr = A_CNT;
      #1;
      n_total++;
      if (bus.hit !== 1'b0)
         $display("FAIL t5_nohit: got %b expected 0", bus.hit);
      else n_pass++;
      rd(A_CNT);
      chk("t5_rdata_hold", bus.rdata, 32'h0000_0001);
`endif
   endtask

   task automatic test_decode();
      do_reset();
      rd(A_STAT);
      chk("t6_status", bus.rdata, 32'h0000_0001);
      bus.addr = A_UART;
      #1;
      n_total++;
      if (bus.hit !== 1'b1)
         $display("FAIL t6_hit_uart: got %b expected 1", bus.hit);
      else n_pass++;
      rd(A_UART);
      chk("t6_read_uart", bus.rdata, 32'h0);
      rd(A_STAT);
      chk("t6_status2", bus.rdata, 32'h0000_0001);
      bus.addr = A_NONE;
      #1;
      n_total++;
      if (bus.hit !== 1'b0)
         $display("FAIL t6_hit_none: got %b expected 0", bus.hit);
      else n_pass++;
      rd(A_NONE);
      chk("t6_rdata_hold", bus.rdata, 32'h0000_0001);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_overflow();
      test_full_pop_push();
      test_mid_reset();
      test_counter();
      test_decode();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mmio_uart_hub.md
# mmio_uart_hub

Memory-mapped peripheral hub placed on the CPU's memory-access path beside the RAM. It replaces the direct store-to-UART strobe with the following:
- a parametrised TX FIFO feeding an 8N1 serialiser, with a readable status register and a sticky overflow flag;
- an optionally compiled-in loadable cycle counter.

Stores and loads whose address matches a hub register are claimed by the hub. The core's existing RAM write-enable and load mux are gated with `hit`.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 868: `clk` cycles per UART bit (100 MHz / 115200); must be ≥2.
- `UART_ADDR`, 32'hF6FFF000: TX data register; write-only, byte in `wdata[7:0]`.
- `STATUS_ADDR`, 32'hF6FFF004: status register; read and write.
- `COUNTER_ADDR`, 32'hF6FFF008: cycle counter register; read and write.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `addr` in 32: byte address of the current access.
- `wdata` in 32: store data.
- `we` in 1: one-cycle store strobe.
- `re` in 1: one-cycle load strobe.
- `hit` out 1: combinational; 1 when `addr` equals any hub register address.
- `rdata` out 32: registered load data.
- `uart_tx` out 1: serial line, idle high.

## Operation
- **Decode.** `we`/`re` act only when `hit`=1. `we` and `re` asserted together: the write takes effect and `rdata` still updates.
- **UART_ADDR write.**
  - FIFO not full: push `wdata[7:0]`.
  - FIFO full: drop the byte and set the `ovf` flag.
  - Full FIFO with a pop in the same cycle: the push is accepted and `ovf` is not set.
  - Reading UART_ADDR returns 0.
- **STATUS read.** `{16'b0, count[7:0], 4'b0, ovf, busy, full, empty}`.
  - `count` width is $clog2(FIFO_DEPTH+1), zero-extended into 8 bits.
  - `busy`=1 while the serialiser FSM is not IDLE.
- **STATUS write.** `wdata[3]`=1 clears `ovf`. All other bits are ignored. A clear and a set in the same cycle: the set wins.
- **COUNTER.**
  - Free-running 32-bit counter, +1 every cycle, wraps from FFFFFFFF to 0.
  - A write loads `wdata`; the counter reads `wdata`+1 on the following cycle.
  - A read returns the pre-edge value.
- **Serialiser FSM.** States IDLE → START → DATA → STOP → IDLE.
  - IDLE with FIFO not empty: pop the head into the shift register, clear the bit counter and move to START.
  - START drives 0. DATA drives `shift[0]`, LSB first, for 8 bits. STOP drives 1.
  - Each state lasts CLKS_PER_BIT cycles, timed by a baud counter reloaded on every state or bit change.
  - STOP end: go to IDLE. If the FIFO is non-empty, the next START begins one cycle later, so the inter-frame gap is exactly 1 cycle.
- **FIFO.** Read/write pointers are $clog2(FIFO_DEPTH) bits wide, wrap naturally, and are tracked with a separate count. Push and pop in the same cycle leaves `count` unchanged.

## Timing
- `rdata` is valid in the cycle after `re`. It holds its value until the next hub read and is 0 after reset.
- Write-to-line latency: a push into an empty FIFO with FSM IDLE makes `uart_tx` fall 2 cycles after the `we` edge (push, then pop/START).
- Frame length: 10×CLKS_PER_BIT cycles.
- Reset values (take effect on the edge where `rst`=1, including mid-frame):
  - FIFO empty, `ovf`=0, FSM IDLE, `uart_tx`=1, counter=0, `rdata`=0.
  - A frame in progress is abandoned; a truncated frame on the line is acceptable.
- `uart_tx` is registered, with no combinational path from inputs.

## Configuration
- `MMIO_HUB_COUNTER_EN` defined: the cycle counter is present as described above.
- Not defined:
  - No counter logic is built.
  - COUNTER_ADDR is not decoded: `hit`=0 there, so the access falls through to RAM.

## Structure
- Register address constants, STATUS bit indices and FSM state encodings go in the shared `define.v`, next to the existing UART and counter addresses.
- One sub-module, `sync_fifo` (parameters: width, depth), holds the storage, pointers and count, with full/empty outputs.
- The serialiser, decode and counter stay in `mmio_uart_hub`.

## Test plan
Each scenario uses CLKS_PER_BIT=4 and FIFO_DEPTH=4.
1. Write 0x55 to UART_ADDR → `uart_tx` shows 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles, start at edge+2. `busy` reads 1 during the frame and 0 after 40 cycles.
2. Write 6 bytes back-to-back → 5 are transmitted (1 popped immediately, 4 in the FIFO) and STATUS reads `ovf`=1. Writing STATUS with 0x8 → `ovf`=0.
3. Fill the FIFO, then write in the pop cycle (FSM leaving IDLE) → byte accepted, `ovf` stays 0, `count`=4.
4. Assert `rst` mid-DATA → next cycle `uart_tx`=1, STATUS=0x00000001, and nothing further is transmitted.
5. With the counter compiled in: write 0xFFFFFFFE to COUNTER, then read in the next cycle → 0xFFFFFFFF; a read 2 cycles later → 0x00000001. With the macro undefined: `hit`=0 at COUNTER_ADDR.
6. Read UART_ADDR → `rdata`=0 one cycle later. Access an unmapped address → `hit`=0 and `rdata` is unchanged.
